sram_line_controller: RTL and testbench

- Responder end of the cache-to-memory interface. Accepts line reads and word writes from the cache controller and serves them from an external 16-bit asynchronous SRAM.
- A read returns a full 64-bit cache line, built from four halfword SRAM reads.
- A write stores one 32-bit word as two halfword SRAM writes, which keeps the cache write-through path simple.
- Sits between the cache controller and the board SRAM pins. Its ready signal is the cache's sram_ready.

---
 rtl/sram_line_controller.sv | 130 +++++++++++++
 tb/tb_sram_line_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_line_controller.sv
// Cache-side responder for a 16-bit asynchronous SRAM: 64-bit line reads built
// from four halfword accesses, 32-bit word writes split into two halfword accesses.
module sram_line_controller #(
  parameter int ACCESS_CYCLES = 2,
  parameter int SRAM_AW       = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  input  logic               write,
  input  logic               sram_mem_r_en,
  output logic [63:0]        sram_rdata,
  output logic               sram_ready,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [15:0]        SRAM_DQ,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [3:0] LAST_CYC = 4'(ACCESS_CYCLES - 1);

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cyc;
  logic [1:0]          r_k;
  logic [SRAM_AW-1:0]  r_base;
  logic [31:0]         r_wdata;
  logic [47:0]         r_line;
  logic [63:0]         r_rdata;
  logic                w_last_cyc;
  logic                w_last_hw;
  logic                w_we_n;
  logic                w_oe_n;
  logic                w_drive;
  logic                w_ready;
  logic                w_unused_addr;

  assign w_unused_addr = ^{address[31:SRAM_AW+1], address[1:0]};

  assign w_last_cyc = (r_cyc == LAST_CYC);
  assign w_last_hw  = (r_state == READ) ? (r_k == 2'd3) : (r_k == 2'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_we_n  = 1'b1;
    w_oe_n  = 1'b1;
    w_drive = 1'b0;
    w_ready = 1'b0;
    case (r_state)
      IDLE: begin
        if (write)              w_next = WRITE;
        else if (sram_mem_r_en) w_next = READ;
      end
      READ: begin
        w_oe_n = 1'b0;
        if (w_last_cyc && w_last_hw) w_next = DONE;
      end
      WRITE: begin
        w_drive = 1'b1;
        // Release WE one cycle early so address and data are held past the rising edge.
        w_we_n  = (ACCESS_CYCLES > 1) && w_last_cyc;
        if (w_last_cyc && w_last_hw) w_next = DONE;
      end
      DONE: begin
        w_ready = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cyc   <= 4'd0;
      r_k     <= 2'd0;
      r_base  <= '0;
      r_rdata <= 64'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cyc <= 4'd0;
          r_k   <= 2'd0;
          if (write)              r_base <= {address[SRAM_AW:2], 1'b0};
          else if (sram_mem_r_en) r_base <= {address[SRAM_AW:3], 2'b00};
        end
        READ, WRITE: begin
          if (w_last_cyc) begin
            r_cyc <= 4'd0;
            r_k   <= w_last_hw ? 2'd0 : r_k + 2'd1;
            // The whole line is published at once, so an aborted read never leaks out.
            if (r_state == READ && w_last_hw) r_rdata <= {SRAM_DQ, r_line};
          end else begin
            r_cyc <= r_cyc + 4'd1;
          end
        end
        default: begin
          r_cyc <= 4'd0;
          r_k   <= 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && write) r_wdata <= wdata;
    if (r_state == READ && w_last_cyc) r_line <= {SRAM_DQ, r_line[47:16]};
  end

  assign SRAM_DQ    = w_drive ? (r_k[0] ? r_wdata[31:16] : r_wdata[15:0]) : 16'hzzzz;
  assign SRAM_ADDR  = r_base + {{(SRAM_AW-2){1'b0}}, r_k};
  assign SRAM_WE_N  = w_we_n;
  assign SRAM_OE_N  = w_oe_n;
  assign SRAM_CE_N  = ~rst;
  assign SRAM_UB_N  = ~rst;
  assign SRAM_LB_N  = ~rst;
  assign sram_ready = w_ready;
  assign sram_rdata = r_rdata;

endmodule

// File: tb/tb_sram_line_controller.sv
// Bench for sram_line_controller: two instances (ACCESS_CYCLES 2 and 1), each on
// its own SRAM array, compared against a shadow memory and timing rules.
module tb_sram_line_controller;
  localparam int AW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wr_in [2];
  logic        rd_in [2];
  logic [31:0] a_in  [2];
  logic [31:0] d_in  [2];
  logic [63:0] rdata [2];
  logic        rdy   [2];
  logic [AW-1:0] saddr [2];
  logic        we_n [2];
  logic        oe_n [2];
  logic        ce_n [2];
  logic        ub_n [2];
  logic        lb_n [2];
  wire  [15:0] dq0;
  wire  [15:0] dq1;

  bit [15:0]   mem    [2][0:(1<<AW)-1];
  bit [15:0]   shadow [2][0:(1<<AW)-1];
  logic [63:0] exp_rdata [2];
  int          checks = 0;
  int          passes = 0;

  assign dq0 = (!oe_n[0] && we_n[0]) ? mem[0][saddr[0]] : 16'hzzzz;
  assign dq1 = (!oe_n[1] && we_n[1]) ? mem[1][saddr[1]] : 16'hzzzz;

  sram_line_controller #(.ACCESS_CYCLES(2), .SRAM_AW(AW)) u_ac2 (
    .clk(clk), .rst(rst), .address(a_in[0]), .wdata(d_in[0]), .write(wr_in[0]),
    .sram_mem_r_en(rd_in[0]), .sram_rdata(rdata[0]), .sram_ready(rdy[0]),
    .SRAM_ADDR(saddr[0]), .SRAM_DQ(dq0), .SRAM_WE_N(we_n[0]), .SRAM_OE_N(oe_n[0]),
    .SRAM_CE_N(ce_n[0]), .SRAM_UB_N(ub_n[0]), .SRAM_LB_N(lb_n[0]));

  sram_line_controller #(.ACCESS_CYCLES(1), .SRAM_AW(AW)) u_ac1 (
    .clk(clk), .rst(rst), .address(a_in[1]), .wdata(d_in[1]), .write(wr_in[1]),
    .sram_mem_r_en(rd_in[1]), .sram_rdata(rdata[1]), .sram_ready(rdy[1]),
    .SRAM_ADDR(saddr[1]), .SRAM_DQ(dq1), .SRAM_WE_N(we_n[1]), .SRAM_OE_N(oe_n[1]),
    .SRAM_CE_N(ce_n[1]), .SRAM_UB_N(ub_n[1]), .SRAM_LB_N(lb_n[1]));

  function automatic int ac_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [15:0] dqv(input int i);
    return (i == 0) ? dq0 : dq1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic reset_checks(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_rdata"}, rdata[i], 64'd0);
      check({tag, "_ctl"},
            64'({rdy[i], we_n[i], oe_n[i], ce_n[i], ub_n[i], lb_n[i], saddr[i]}),
            64'({1'b0, 5'b11111, 18'd0}));
    end
  endtask

  // Raise a request in an idle cycle; the next rising edge accepts it.
  task automatic start(input int i, input bit wr, input bit rd,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    check("idle_ready", 64'(rdy[i]), 64'd0);
    wr_in[i] = wr; rd_in[i] = rd; a_in[i] = a; d_in[i] = d;
  endtask

  // Follow one operation to its ready pulse; skip = idle cycles expected before acceptance.
  task automatic do_op(input int i, input bit is_wr, input int skip, input bit nwr, input bit nrd);
    int          ac    = ac_of(i);
    int          n     = is_wr ? 2 : 4;
    logic [31:0] a     = a_in[i];
    logic [31:0] d     = d_in[i];
    int          abyte = int'(a % 32'(1 << (AW + 1)));
    int          base  = is_wr ? (abyte / 4) * 2 : (abyte / 8) * 4;
    bit          walk_ok = 1'b1;
    bit          scram;
    int          lat  = -1;
    int          welo = 0;
    int          j    = 0;
    int          k;
    int          c;
    scram = !nwr && !nrd;
    while (lat < 0 && j <= 200) begin
      @(negedge clk);
      if (!we_n[i]) begin
        mem[i][saddr[i]] = dqv(i);
        welo++;
      end
      if (scram && j == skip) begin
        a_in[i] = $urandom;
        d_in[i] = $urandom;
      end
      if (rdy[i]) begin
        lat = j;
        if (we_n[i] !== 1'b1 || oe_n[i] !== 1'b1) walk_ok = 1'b0;
      end else if (j >= skip && j < skip + n * ac) begin
        k = (j - skip) / ac;
        c = (j - skip) % ac;
        if (saddr[i] !== AW'(base + k)) walk_ok = 1'b0;
        if (is_wr) begin
          if (oe_n[i] !== 1'b1 || dqv(i) !== ((k == 1) ? d[31:16] : d[15:0])) walk_ok = 1'b0;
          if (we_n[i] !== ((ac > 1 && c == ac - 1) ? 1'b1 : 1'b0)) walk_ok = 1'b0;
        end else if (oe_n[i] !== 1'b0 || we_n[i] !== 1'b1) begin
          walk_ok = 1'b0;
        end
      end else if (we_n[i] !== 1'b1 || oe_n[i] !== 1'b1) begin
        walk_ok = 1'b0;
      end
      j++;
    end
    check("walk", 64'(walk_ok), 64'd1);
    check("latency", 64'(lat), 64'(skip + n * ac));
    check("we_low_cycles", 64'(welo), is_wr ? 64'(n * ((ac > 1) ? ac - 1 : 1)) : 64'd0);
    if (is_wr) begin
      shadow[i][base]     = d[15:0];
      shadow[i][base + 1] = d[31:16];
      check("wr_mem", 64'({mem[i][base + 1], mem[i][base]}),
            64'({shadow[i][base + 1], shadow[i][base]}));
    end else begin
      exp_rdata[i] = {shadow[i][base + 3], shadow[i][base + 2],
                      shadow[i][base + 1], shadow[i][base]};
    end
    check("rdata", rdata[i], exp_rdata[i]);
    wr_in[i] = nwr;
    rd_in[i] = nrd;
  endtask

  initial begin
    int          ri;
    bit          rw;
    logic [31:0] ra;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_in[i] = 1'b0; rd_in[i] = 1'b0; a_in[i] = 32'd0; d_in[i] = 32'd0;
      exp_rdata[i] = 64'd0;
    end
    for (int h = 0; h < 1024; h++) begin
      int v;
      v = $urandom;
      mem[0][h] = v[15:0];  shadow[0][h] = v[15:0];
      mem[1][h] = v[31:16]; shadow[1][h] = v[31:16];
    end
    for (int i = 0; i < 2; i++) begin
      for (int h = 0; h < 4; h++) begin
        mem[i][32'h100 + h]    = 16'h1111 * 16'(h + 1);
        shadow[i][32'h100 + h] = 16'h1111 * 16'(h + 1);
      end
    end

    #12;
    reset_checks("por");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ce_ub_lb_active", 64'({ce_n[0], ub_n[0], lb_n[0], ce_n[1], ub_n[1], lb_n[1]}), 64'd0);

    // Reset during read access k=2 abandons the line.
    start(0, 1'b0, 1'b1, 32'h0000_0204, 32'd0);
    repeat (5) @(negedge clk);
    check("k2_addr", 64'(saddr[0]), 64'h102);
    rst = 1'b0;
    #1;
    reset_checks("abort");
    rd_in[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rdata_after_abort", rdata[0], 64'd0);

    // Line read and word write.
    start(0, 1'b0, 1'b1, 32'h0000_0204, 32'd0);
    do_op(0, 1'b0, 0, 1'b0, 1'b0);
    check("line_value", rdata[0], 64'h4444_3333_2222_1111);
    start(0, 1'b1, 1'b0, 32'h0000_0208, 32'hDEAD_BEEF);
    do_op(0, 1'b1, 0, 1'b0, 1'b0);
    check("wr_beef", 64'(mem[0][32'h104]), 64'hBEEF);
    check("wr_dead", 64'(mem[0][32'h105]), 64'hDEAD);
    check("rdata_kept", rdata[0], 64'h4444_3333_2222_1111);

    // Both requests: write first, held read taken after one idle cycle.
    start(0, 1'b1, 1'b1, 32'h0000_0210, 32'h0BAD_F00D);
    do_op(0, 1'b1, 0, 1'b0, 1'b1);
    do_op(0, 1'b0, 1, 1'b0, 1'b0);

    // Requests held through DONE.
    start(0, 1'b0, 1'b1, 32'h0000_0204, 32'd0);
    do_op(0, 1'b0, 0, 1'b0, 1'b1);
    do_op(0, 1'b0, 1, 1'b0, 1'b0);
    start(0, 1'b1, 1'b0, 32'h0000_020C, $urandom);
    do_op(0, 1'b1, 0, 1'b1, 1'b0);
    do_op(0, 1'b1, 1, 1'b0, 1'b0);

    // Single-cycle accesses.
    start(1, 1'b0, 1'b1, 32'h0000_0204, 32'd0);
    do_op(1, 1'b0, 0, 1'b0, 1'b0);
    check("line_value_ac1", rdata[1], 64'h4444_3333_2222_1111);
    start(1, 1'b1, 1'b0, 32'h0000_0208, 32'hDEAD_BEEF);
    do_op(1, 1'b1, 0, 1'b0, 1'b0);
    start(1, 1'b0, 1'b1, 32'hFFF8_0208, 32'd0);
    do_op(1, 1'b0, 0, 1'b0, 1'b0);
    check("rd_after_wr_ac1", 64'(rdata[1][31:0]), 64'hDEAD_BEEF);

    // Random mix on both instances.
    repeat (30) begin
      ri = int'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      ra = ($urandom & 32'hFFF8_0000) | $urandom_range(0, 32'h7FF);
      start(ri, rw, !rw || 1'($urandom_range(0, 1)), ra, $urandom);
      do_op(ri, rw, 0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
